rtc_hms_ctrl: RTL and testbench
===============================

Name: rtc_hms_ctrl

Overview:
Parametrised real-time clock. Divides the system clock to a 1 s tick and keeps HH:MM:SS as BCD digit counters. Adds run/stop, a validated time-set handshake, a 12/24-hour output mode and an optional alarm. Feeds the seven-segment and MMIO status path with a registered packed BCD word.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; prescaler wraps at CLK_HZ-1 (bench uses 10)
PRESC_W, 27, prescaler width; must satisfy 2^PRESC_W >= CLK_HZ

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
run  in  1  1 = count, 0 = freeze prescaler and time
mode12  in  1  0 = 24 h output, 1 = 12 h output with PM flag
set_valid  in  1  single-cycle request to load set_bcd
set_bcd  in  24  {HH,MM,SS} BCD, always 24 h format
set_ack  out  1  one-cycle pulse: load accepted
set_err  out  1  one-cycle pulse: load rejected
tick_1s  out  1  one-cycle pulse on each prescaler wrap
hms_bcd  out  32  registered {flags,HH,MM,SS}
alarm_en  in  1  alarm arm (RTC_ALARM_EN only)
alarm_bcd  in  24  alarm time {HH,MM,SS} BCD, 24 h (RTC_ALARM_EN only)
alarm_clr  in  1  clears alarm_irq (RTC_ALARM_EN only)
alarm_irq  out  1  sticky alarm flag (RTC_ALARM_EN only)

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high. Reset clears all state.
- Reset values: prescaler 0, time 00:00:00, hms_bcd 32'h0, tick_1s/set_ack/set_err/alarm_irq 0.
- Prescaler: increments while run=1; on value CLK_HZ-1 it wraps to 0 and asserts tick_1s that same cycle (combinational from prescaler==CLK_HZ-1 && run, or registered equivalently — must be high for exactly the wrap cycle). Holds when run=0.
- Time counters: six BCD digits (h1,h0,m1,m0,s1,s0). Each tick advances seconds; SS 59->00 carries into MM; MM 59->00 carries into HH; HH 23->00. No binary-to-BCD division.
- Set handshake: set_valid sampled each cycle. Valid when every nibble <=9, HH<=23, MM<=59, SS<=59.
  - Valid: load digits, clear prescaler to 0, set_ack=1 next cycle.
  - Invalid: time and prescaler unchanged, set_err=1 next cycle.
  - Set and tick in the same cycle: the set wins; the tick increment is discarded; tick_1s still pulses.
  - Set is accepted regardless of run.
- Output: hms_bcd is registered from the counters, one cycle behind them.
  - mode12=0: [31:24]=8'h00, [23:0]={HH,MM,SS}.
  - mode12=1: bit24 = PM (HH>=12), [31:25]=0. Hour mapping: 00->12 AM, 01..11 unchanged AM, 12->12 PM, 13..23 -> 01..11 PM.
  - A mode12 change is reflected on the next cycle.
- Reset mid-count or mid-set: everything returns to reset values; any pending ack/err pulse is dropped.

Optional Feature:
RTC_ALARM_EN defined:
- alarm_irq is set, one cycle later, in any cycle where a tick advances the time to a value equal to alarm_bcd while alarm_en=1.
- A set load that happens to match does not trigger the alarm.
- alarm_irq stays set until alarm_clr=1. If clear and set occur in the same cycle, set wins.
- alarm_bcd is not range-checked; an invalid alarm_bcd simply never matches.
RTC_ALARM_EN undefined:
- alarm ports remain present; inputs are ignored; alarm_irq is tied to 0; no alarm logic is synthesised.

Test Plan (CLK_HZ=10):
- Reset/tick: hold rst 3 cycles, release with run=1 -> hms_bcd=0. First tick_1s on the 10th cycle after release; hms_bcd=32'h00000001 one cycle after that tick.
- Rollover: set 24'h235959, then one tick -> time 00:00:00, hms_bcd=32'h00000000. Set 24'h095959, then one tick -> 32'h00100000.
- Invalid set: 24'h245900, 24'h126000 and 24'h1A0000 -> set_err pulse each, no set_ack, time unchanged. A valid set 24'h123456 -> set_ack and hms_bcd=32'h00123456.
- 12 h mode: mode12=1 with time 00:00:00 -> 32'h00120000. Time 12:00:00 -> 32'h01120000. Time 13:05:09 -> 32'h01010509.
- Run/priority: run=0 for 50 cycles -> no tick, value frozen. Assert set_valid (24'h010203) on the exact wrap cycle -> result 01:02:03, not 01:02:04.
- Alarm (RTC_ALARM_EN): alarm_bcd=24'h000005, alarm_en=1, start from 0 -> alarm_irq rises after the 5th tick and stays set. alarm_clr -> 0. Repeat with alarm_en=0 -> alarm_irq stays 0.

Source files
------------

// File: rtl/rtc_hms_ctrl.sv
// Real-time clock: divides clk to a 1 s tick and keeps HH:MM:SS as BCD digits, with
// a validated set handshake, 12/24 h output and an optional alarm (macro RTC_ALARM_EN).
module rtc_hms_ctrl #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned PRESC_W = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        mode12,
   input  logic        set_valid,
   input  logic [23:0] set_bcd,
   output logic        set_ack,
   output logic        set_err,
   output logic        tick_1s,
   output logic [31:0] hms_bcd,
   input  logic        alarm_en,
   input  logic [23:0] alarm_bcd,
   input  logic        alarm_clr,
   output logic        alarm_irq
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [23:0]        time_q, time_d, time_inc;
   logic [31:0]        hms_q, hms_d;
   logic               set_ack_q, set_err_q;
   logic               wrap, set_ok, set_hit;
   logic [8:0]         hour12;

   // Advance {HH,MM,SS} by one second, digit by digit with explicit carries.
   // NOTE: function locals are scratch variables, so blocking '=' is correct here;
   // only the clocked block below updates state, and it uses '<='.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [3:0] h1, h0, m1, m0, s1, s0;
      {h1, h0, m1, m0, s1, s0} = t;
      if (s0 != 4'd9) begin
         s0 = s0 + 4'd1;
      end else begin
         s0 = 4'd0;
         if (s1 != 4'd5) begin
            s1 = s1 + 4'd1;
         end else begin
            s1 = 4'd0;
            if (m0 != 4'd9) begin
               m0 = m0 + 4'd1;
            end else begin
               m0 = 4'd0;
               if (m1 != 4'd5) begin
                  m1 = m1 + 4'd1;
               end else begin
                  m1 = 4'd0;
                  if (h1 == 4'd2 && h0 == 4'd3) begin
                     h1 = 4'd0;
                     h0 = 4'd0;
                  end else if (h0 == 4'd9) begin
                     h0 = 4'd0;
                     h1 = h1 + 4'd1;
                  end else begin
                     h0 = h0 + 4'd1;
                  end
               end
            end
         end
      end
      return {h1, h0, m1, m0, s1, s0};
   endfunction

   function automatic logic bcd_valid(input logic [23:0] t);
      logic [3:0] h1, h0, m1, m0, s1, s0;
      logic       digits_ok;
      {h1, h0, m1, m0, s1, s0} = t;
      digits_ok = (h1 <= 4'd9) && (h0 <= 4'd9) && (m1 <= 4'd9) &&
                  (m0 <= 4'd9) && (s1 <= 4'd9) && (s0 <= 4'd9);
      return digits_ok && (h1 < 4'd2 || (h1 == 4'd2 && h0 <= 4'd3)) &&
             (m1 <= 4'd5) && (s1 <= 4'd5);
   endfunction

   // Returns {pm, hh} for 12 h display; a lookup avoids any BCD arithmetic on hours.
   function automatic logic [8:0] to_12h(input logic [7:0] hh);
      logic [8:0] r;
      case (hh)
         8'h00: r = {1'b0, 8'h12};
         8'h12: r = {1'b1, 8'h12};
         8'h13: r = {1'b1, 8'h01};
         8'h14: r = {1'b1, 8'h02};
         8'h15: r = {1'b1, 8'h03};
         8'h16: r = {1'b1, 8'h04};
         8'h17: r = {1'b1, 8'h05};
         8'h18: r = {1'b1, 8'h06};
         8'h19: r = {1'b1, 8'h07};
         8'h20: r = {1'b1, 8'h08};
         8'h21: r = {1'b1, 8'h09};
         8'h22: r = {1'b1, 8'h10};
         8'h23: r = {1'b1, 8'h11};
         default: r = {1'b0, hh};
      endcase
      return r;
   endfunction

   // NOTE: every signal gets its default before any branch, so no latch can be inferred.
   always_comb begin
      wrap     = run && (presc_q == PRESC_MAX);
      set_ok   = bcd_valid(set_bcd);
      set_hit  = set_valid && set_ok;
      time_inc = bcd_inc(time_q);
      hour12   = to_12h(time_q[23:16]);

      presc_d = presc_q;
      if (set_hit || wrap) begin
         presc_d = '0;
      end else if (run) begin
         presc_d = presc_q + PRESC_W'(1);
      end

      // A set in the wrap cycle wins; that tick's increment is dropped.
      time_d = time_q;
      if (set_hit) begin
         time_d = set_bcd;
      end else if (wrap) begin
         time_d = time_inc;
      end

      hms_d = {8'h00, time_q};
      if (mode12) begin
         hms_d = {7'b0, hour12, time_q[15:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         time_q    <= '0;
         hms_q     <= '0;
         set_ack_q <= 1'b0;
         set_err_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         time_q    <= time_d;
         hms_q     <= hms_d;
         set_ack_q <= set_hit;
         set_err_q <= set_valid && !set_ok;
      end
   end

   assign tick_1s = wrap;
   assign set_ack = set_ack_q;
   assign set_err = set_err_q;
   assign hms_bcd = hms_q;

`ifdef RTC_ALARM_EN
   logic alarm_irq_q, alarm_hit;

   // Only a real tick advance can match; a set load never fires the alarm.
   assign alarm_hit = wrap && !set_hit && alarm_en && (time_inc == alarm_bcd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_irq_q <= 1'b0;
      end else if (alarm_hit) begin
         alarm_irq_q <= 1'b1;
      end else if (alarm_clr) begin
         alarm_irq_q <= 1'b0;
      end
   end

   assign alarm_irq = alarm_irq_q;
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_en, alarm_bcd, alarm_clr};
   assign alarm_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_hms_ctrl.sv
// Directed bench for rtc_hms_ctrl at CLK_HZ=10; alarm checks follow RTC_ALARM_EN.
module tb_rtc_hms_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        mode12;
   logic        set_valid;
   logic [23:0] set_bcd;
   logic        set_ack;
   logic        set_err;
   logic        tick_1s;
   logic [31:0] hms_bcd;
   logic        alarm_en;
   logic [23:0] alarm_bcd;
   logic        alarm_clr;
   logic        alarm_irq;

   int n_vec = 0;
   int n_err = 0;

   rtc_hms_ctrl #(.CLK_HZ(10), .PRESC_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .mode12    (mode12),
      .set_valid (set_valid),
      .set_bcd   (set_bcd),
      .set_ack   (set_ack),
      .set_err   (set_err),
      .tick_1s   (tick_1s),
      .hms_bcd   (hms_bcd),
      .alarm_en  (alarm_en),
      .alarm_bcd (alarm_bcd),
      .alarm_clr (alarm_clr),
      .alarm_irq (alarm_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load a value; returns the ack/err seen one cycle later and leaves hms_bcd updated.
   task automatic do_set(input logic [23:0] v, output logic ack, output logic err);
      set_valid = 1'b1;
      set_bcd   = v;
      step();
      set_valid = 1'b0;
      ack = set_ack;
      err = set_err;
      step();
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!tick_1s && n < 40) begin
         step();
         n++;
      end
      if (!tick_1s) check("tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic ack, err;
      int   n;
      int   ticks;

      rst = 1'b1; run = 1'b0; mode12 = 1'b0; set_valid = 1'b0; set_bcd = '0;
      alarm_en = 1'b0; alarm_bcd = '0; alarm_clr = 1'b0;
      repeat (3) step();
      check("rst_hms", hms_bcd, 32'h0);
      check("rst_tick", {31'b0, tick_1s}, 32'd0);
      check("rst_ack_err", {30'b0, set_ack, set_err}, 32'd0);
      check("rst_irq", {31'b0, alarm_irq}, 32'd0);

      // First tick lands on the 10th cycle after release
      rst = 1'b0; run = 1'b1;
      n = 1;
      while (!tick_1s && n < 20) begin
         step();
         n++;
      end
      check("first_tick_cycle", n, 10);
      step();
      step();
      check("first_second", hms_bcd, 32'h00000001);

      // Rollovers
      do_set(24'h235959, ack, err);
      check("set_235959", hms_bcd, 32'h00235959);
      wait_tick(); step(); step();
      check("roll_day", hms_bcd, 32'h00000000);
      do_set(24'h095959, ack, err);
      wait_tick(); step(); step();
      check("roll_hour", hms_bcd, 32'h00100000);

      // Invalid sets leave time alone
      run = 1'b0;
      do_set(24'h245900, ack, err);
      check("bad_hh_err", {30'b0, ack, err}, 32'd1);
      do_set(24'h126000, ack, err);
      check("bad_mm_err", {30'b0, ack, err}, 32'd1);
      do_set(24'h1A0000, ack, err);
      check("bad_nib_err", {30'b0, ack, err}, 32'd1);
      check("bad_unchanged", hms_bcd, 32'h00100000);
      do_set(24'h123456, ack, err);
      check("good_ack", {30'b0, ack, err}, 32'd2);
      check("good_hms", hms_bcd, 32'h00123456);
      check("ack_pulse", {31'b0, set_ack}, 32'd0);

      // 12 h mode
      do_set(24'h000000, ack, err);
      mode12 = 1'b1;
      step();
      check("h12_midnight", hms_bcd, 32'h00120000);
      do_set(24'h120000, ack, err);
      check("h12_noon", hms_bcd, 32'h01120000);
      do_set(24'h115959, ack, err);
      check("h12_1159", hms_bcd, 32'h00115959);
      do_set(24'h235959, ack, err);
      check("h12_2359", hms_bcd, 32'h01115959);
      do_set(24'h130509, ack, err);
      check("h12_1305", hms_bcd, 32'h01010509);
      mode12 = 1'b0;
      step();
      check("h24_back", hms_bcd, 32'h00130509);

      // Freeze
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (tick_1s) ticks++;
      end
      check("freeze_ticks", ticks, 0);
      check("freeze_hms", hms_bcd, 32'h00130509);

      // Set on the wrap cycle beats the tick
      run = 1'b1;
      wait_tick();
      set_valid = 1'b1;
      set_bcd   = 24'h010203;
      step();
      set_valid = 1'b0;
      check("prio_ack", {31'b0, set_ack}, 32'd1);
      step();
      check("prio_hms", hms_bcd, 32'h00010203);

`ifdef RTC_ALARM_EN
      run = 1'b0;
      alarm_bcd = 24'h000005;
      alarm_en  = 1'b1;
      do_set(24'h000005, ack, err);
      check("alarm_set_nomatch", {31'b0, alarm_irq}, 32'd0);
      do_set(24'h000000, ack, err);
      run = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         wait_tick();
         step();
         check($sformatf("alarm_t%0d", t), {31'b0, alarm_irq}, {31'b0, t == 5});
      end
      repeat (20) step();
      check("alarm_sticky", {31'b0, alarm_irq}, 32'd1);
      alarm_clr = 1'b1;
      step();
      alarm_clr = 1'b0;
      check("alarm_clr", {31'b0, alarm_irq}, 32'd0);
      alarm_en = 1'b0;
      do_set(24'h000000, ack, err);
      repeat (6) begin
         wait_tick();
         step();
      end
      check("alarm_disabled", {31'b0, alarm_irq}, 32'd0);
`else
      alarm_en  = 1'b1;
      alarm_bcd = 24'h000001;
      do_set(24'h000000, ack, err);
      wait_tick();
      step();
      step();
      check("alarm_absent_time", hms_bcd, 32'h00000001);
      check("alarm_absent_irq", {31'b0, alarm_irq}, 32'd0);
`endif

      // Reset in the middle of a pending error pulse
      run = 1'b1;
      set_valid = 1'b1;
      set_bcd   = 24'h990000;
      step();
      set_valid = 1'b0;
      check("pre_rst_err", {31'b0, set_err}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_err", {31'b0, set_err}, 32'd0);
      check("mid_rst_hms", hms_bcd, 32'h0);
      check("mid_rst_tick", {31'b0, tick_1s}, 32'd0);
      step();
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
